// File: rtl/spi_receiver.sv
// SPI peripheral-side receiver: oversamples SCK/CS/MOSI in the clk_100 domain and deserialises
// MSB-first words onto a valid/ready stream.
module spi_receiver #(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter bit          P_CPOL       = 1'b0,
  parameter bit          P_CPHA       = 1'b0
) (
  input  logic                    clk_100,
  input  logic                    s_rst,
  input  logic                    SCK,
  input  logic                    CS,
  input  logic                    MOSI,
  output logic [P_DATA_WIDTH-1:0] data_out,
  output logic                    valid,
  input  logic                    ready,
  output logic                    busy,
  output logic                    overrun,
  output logic                    frame_err
);

  localparam int unsigned LP_CNT_W = (P_DATA_WIDTH > 2) ? $clog2(P_DATA_WIDTH) : 1;
  localparam logic [LP_CNT_W-1:0] LP_LAST = LP_CNT_W'(P_DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    StWaitCsHigh = 2'd0,
    StIdle       = 2'd1,
    StRecv       = 2'd2
  } state_e;

  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_cs_s1, r_cs_s2;
  logic r_mosi_s1, r_mosi_s2;
  logic [1:0] r_warm;

  state_e                  r_state, w_state_next;
  logic [LP_CNT_W-1:0]     r_bit_cnt, w_bit_cnt_next;
  logic [P_DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [P_DATA_WIDTH-1:0] r_data, w_data_next;
  logic                    r_valid, w_valid_next;
  logic                    r_busy, w_busy_next;
  logic                    r_overrun, w_overrun_next;
  logic                    r_frame_err, w_frame_err_next;

  logic                    w_rise, w_fall, w_sample, w_done;
  logic [P_DATA_WIDTH-1:0] w_word;

  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      r_sck_s1  <= P_CPOL;
      r_sck_s2  <= P_CPOL;
      r_sck_d   <= P_CPOL;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_warm    <= 2'b00;
    end else begin
      r_sck_s1  <= SCK;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_cs_s1   <= CS;
      r_cs_s2   <= r_cs_s1;
      r_mosi_s1 <= MOSI;
      r_mosi_s2 <= r_mosi_s1;
      r_warm    <= {r_warm[0], 1'b1};
    end
  end

  assign w_rise   = r_sck_s2 & ~r_sck_d;
  assign w_fall   = ~r_sck_s2 & r_sck_d;
  assign w_sample = (P_CPOL ^ P_CPHA) ? w_fall : w_rise;
  assign w_word   = {r_shift[P_DATA_WIDTH-2:0], r_mosi_s2};

  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      r_state     <= StWaitCsHigh;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_shift     <= w_shift_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
      r_busy      <= w_busy_next;
      r_overrun   <= w_overrun_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_bit_cnt_next   = r_bit_cnt;
    w_shift_next     = r_shift;
    w_frame_err_next = 1'b0;
    w_done           = 1'b0;
    unique case (r_state)
      StWaitCsHigh: begin
        // The CS synchroniser holds its reset value for two cycles; only trust it once flushed.
        if (r_cs_s2 && r_warm[1]) w_state_next = StIdle;
      end
      StIdle: begin
        w_bit_cnt_next = '0;
        if (!r_cs_s2) w_state_next = StRecv;
      end
      StRecv: begin
        if (r_cs_s2) begin
          w_state_next     = StIdle;
          w_bit_cnt_next   = '0;
          w_frame_err_next = (r_bit_cnt != '0);
        end else if (w_sample) begin
          w_shift_next = w_word;
          if (r_bit_cnt == LP_LAST) begin
            w_bit_cnt_next = '0;
            w_done         = 1'b1;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = StWaitCsHigh;
    endcase

    w_data_next    = r_data;
    w_valid_next   = r_valid;
    w_overrun_next = 1'b0;
    if (w_done) begin
      if (!r_valid || ready) begin
        w_data_next  = w_word;
        w_valid_next = 1'b1;
      end else begin
        w_overrun_next = 1'b1;
      end
    end else if (r_valid && ready) begin
      w_valid_next = 1'b0;
    end
    w_busy_next = (w_state_next == StRecv);
  end

  assign data_out  = r_data;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_receiver.sv
// Scoreboard bench for spi_receiver: a mode-0 and a mode-3 instance driven from one initial block.
module tb_spi_receiver;

  logic clk_100 = 1'b0;
  logic s_rst   = 1'b1;
  logic mosi    = 1'b0;
  logic sck0 = 1'b0, cs0 = 1'b1, ready0 = 1'b1;
  logic sck3 = 1'b1, cs3 = 1'b1, ready3 = 1'b0;
  logic [7:0] data_out0, data_out3;
  logic valid0, busy0, overrun0, frame_err0;
  logic valid3, busy3, overrun3, frame_err3;

  always #5 clk_100 = ~clk_100;

  spi_receiver #(.P_DATA_WIDTH(8), .P_CPOL(1'b0), .P_CPHA(1'b0)) u_dut0 (
    .clk_100(clk_100), .s_rst(s_rst), .SCK(sck0), .CS(cs0), .MOSI(mosi),
    .data_out(data_out0), .valid(valid0), .ready(ready0), .busy(busy0),
    .overrun(overrun0), .frame_err(frame_err0)
  );

  spi_receiver #(.P_DATA_WIDTH(8), .P_CPOL(1'b1), .P_CPHA(1'b1)) u_dut3 (
    .clk_100(clk_100), .s_rst(s_rst), .SCK(sck3), .CS(cs3), .MOSI(mosi),
    .data_out(data_out3), .valid(valid3), .ready(ready3), .busy(busy3),
    .overrun(overrun3), .frame_err(frame_err3)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_edge_cyc = 0;
  int v0_rise_cyc = -1;
  int v0_hi = 0, ov0 = 0, fe0 = 0, busy_err = 0;
  int v3_rises = 0, ov3 = 0, fe3 = 0;
  bit v0_prev = 1'b0, v3_prev = 1'b0, chk_busy0 = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q3[$];

  // Sample settled values just before the coming active edge, then advance to the falling edge.
  task automatic mon();
    logic [7:0] exp;
    if (valid0 && ready0) begin
      n_vec++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL beat0_unexpected: got %h, required no beat", data_out0);
      end else begin
        exp = q0.pop_front();
        if (data_out0 !== exp) begin
          n_err++;
          $display("FAIL beat0_data: got %h, required %h", data_out0, exp);
        end
      end
    end
    if (valid3 && ready3) begin
      n_vec++;
      if (q3.size() == 0) begin
        n_err++;
        $display("FAIL beat3_unexpected: got %h, required no beat", data_out3);
      end else begin
        exp = q3.pop_front();
        if (data_out3 !== exp) begin
          n_err++;
          $display("FAIL beat3_data: got %h, required %h", data_out3, exp);
        end
      end
    end
    if (valid0 && !v0_prev) v0_rise_cyc = cyc;
    if (valid3 && !v3_prev) v3_rises++;
    v0_prev = valid0;
    v3_prev = valid3;
    if (valid0) v0_hi++;
    if (overrun0) ov0++;
    if (frame_err0) fe0++;
    if (overrun3) ov3++;
    if (frame_err3) fe3++;
    if (chk_busy0 && !busy0) busy_err++;
  endtask

  task automatic tick();
    mon();
    @(negedge clk_100);
    cyc++;
  endtask

  task automatic wait_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string name, input int got, input int req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // hook raises ready3 in the completion cycle of the final bit.
  task automatic send_bits(input bit m3, input logic [15:0] w, input int n, input bit hook);
    for (int i = n - 1; i >= 0; i--) begin
      if (m3) begin
        sck3 = 1'b0;
        mosi = w[i];
        wait_n(4);
        sck3 = 1'b1;
        last_edge_cyc = cyc;
        for (int t = 0; t < 4; t++) begin
          if (hook && i == 0 && t == 2) ready3 = 1'b1;
          tick();
        end
      end else begin
        mosi = w[i];
        wait_n(4);
        sck0 = 1'b1;
        last_edge_cyc = cyc;
        wait_n(4);
        sck0 = 1'b0;
      end
    end
  endtask

  task automatic frame0(input logic [15:0] w, input int n);
    cs0 = 1'b0;
    wait_n(4);
    send_bits(1'b0, w, n, 1'b0);
    wait_n(4);
    cs0 = 1'b1;
    wait_n(6);
  endtask

  task automatic test_reset();
    s_rst = 1'b1;
    wait_n(3);
    check("rst_data0", int'(data_out0), 0);
    check("rst_valid0", int'(valid0), 0);
    check("rst_busy0", int'(busy0), 0);
    check("rst_pulses0", int'(overrun0) + int'(frame_err0), 0);
    check("rst_data3", int'(data_out3), 0);
    check("rst_valid3", int'(valid3), 0);
    s_rst = 1'b0;
    wait_n(5);
  endtask

  task automatic test_single_word();
    int hi0;
    hi0 = v0_hi;
    q0.push_back(8'hA5);
    frame0(16'h00A5, 8);
    check("m0_latency", v0_rise_cyc - last_edge_cyc, 3);
    check("m0_valid_cycles", v0_hi - hi0, 1);
    check("m0_no_pulses", ov0 + fe0, 0);
    check("m0_drained", q0.size(), 0);
  endtask

  task automatic test_back_to_back();
    int hi0;
    hi0 = v0_hi;
    q0.push_back(8'h3C);
    q0.push_back(8'hC3);
    cs0 = 1'b0;
    wait_n(4);
    chk_busy0 = 1'b1;
    send_bits(1'b0, 16'h3CC3, 16, 1'b0);
    wait_n(4);
    chk_busy0 = 1'b0;
    cs0 = 1'b1;
    wait_n(6);
    check("b2b_beats", v0_hi - hi0, 2);
    check("b2b_busy_held", busy_err, 0);
    check("b2b_frame_err", fe0, 0);
    check("b2b_drained", q0.size(), 0);
  endtask

  task automatic test_overrun();
    ready0 = 1'b0;
    q0.push_back(8'h11);
    frame0(16'h1122, 16);
    check("ovr_valid_held", int'(valid0), 1);
    check("ovr_data_held", int'(data_out0), 'h11);
    check("ovr_pulses", ov0, 1);
    ready0 = 1'b1;
    wait_n(3);
    check("ovr_drained", q0.size(), 0);
    check("ovr_valid_clear", int'(valid0), 0);
  endtask

  task automatic test_frame_err();
    int hi0;
    hi0 = v0_hi;
    frame0(16'h0016, 5);
    check("ferr_pulses", fe0, 1);
    check("ferr_no_valid", v0_hi - hi0, 0);
    q0.push_back(8'h5A);
    frame0(16'h005A, 8);
    check("ferr_recover", q0.size(), 0);
    check("ferr_recover_data", int'(data_out0), 'h5A);
  endtask

  task automatic test_reset_mid_frame();
    int hi0;
    hi0 = v0_hi;
    cs0 = 1'b0;
    wait_n(4);
    send_bits(1'b0, 16'h0005, 3, 1'b0);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    send_bits(1'b0, 16'h0015, 5, 1'b0);
    wait_n(4);
    check("rmf_busy", int'(busy0), 0);
    cs0 = 1'b1;
    wait_n(6);
    check("rmf_no_valid", v0_hi - hi0, 0);
    check("rmf_no_ferr", fe0, 1);
    check("rmf_data_reset", int'(data_out0), 0);
    q0.push_back(8'h96);
    frame0(16'h0096, 8);
    check("rmf_data_new", int'(data_out0), 'h96);
    check("rmf_drained", q0.size(), 0);
  endtask

  task automatic test_mode3_handoff();
    q3.push_back(8'h7E);
    q3.push_back(8'h81);
    cs3 = 1'b0;
    wait_n(4);
    send_bits(1'b1, 16'h007E, 8, 1'b0);
    send_bits(1'b1, 16'h0081, 8, 1'b1);
    wait_n(4);
    cs3 = 1'b1;
    wait_n(6);
    check("m3_data", int'(data_out3), 'h81);
    check("m3_no_gap", v3_rises, 1);
    check("m3_drained", q3.size(), 0);
    check("m3_no_pulses", ov3 + fe3, 0);
    check("m3_idle", int'(busy3), 0);
  endtask

  initial begin
    @(negedge clk_100);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_mid_frame();
    test_mode3_handoff();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
